neopixel_rx: RTL and testbench
==============================

// Module: neopixel_rx
// PURPOSE
//  WS2812 ("neopixel") serial decoder: the receive end of the 800 kbit/s single-wire link our
//  neopixel driver transmits. Oversamples DIN on the 12 MHz CLK, classifies each high pulse
//  as 0/1, packs bits MSB-first into bytes and writes them into a framebuf-style RAM port
//  (9-bit addr, 8-bit data, write enable). Used for loopback self-test and for decoding strips.
// PARAMETERS
//  T1_MIN_CYC    8    high pulse >= this many CLK cycles decodes as 1, else 0 (T0H~5, T1H~10)
//  GLITCH_CYC    2    high pulse < this is a glitch -> protocol error
//  HIGH_MAX_CYC  20   high pulse > this -> protocol error (stuck line)
//  RESET_CYC     600  low time >= this (50 us @12 MHz) = latch/frame gap
//  MAX_BYTES     512  bytes accepted per frame; addresses 0..MAX_BYTES-1
// PORTS
//  CLK         in   1  12 MHz system clock
//  RST_N       in   1  asynchronous active-low reset
//  DIN         in   1  asynchronous WS2812 serial line
//  WADDR       out  9  byte address in frame (0 = G of pixel 0, 1 = R, 2 = B, ...)
//  WDATA       out  8  decoded byte
//  WE          out  1  one-cycle write strobe; WADDR/WDATA valid while high
//  FRAME_DONE  out  1  one-cycle pulse at end of frame (gap detected after >=1 bit)
//  FRAME_BYTES out 10  complete bytes received in the last finished frame (held)
//  ERR         out  1  sticky protocol/overflow error; cleared when next frame's first bit starts
// BEHAVIOUR
//  - Reset: all outputs 0; state WAIT_GAP; bit/byte counters 0; shift reg 0.
//  - DIN passes a 2-flop synchroniser; all timing below is on the synchronised signal (ds).
//  - States: WAIT_GAP, IDLE, HIGH, LOW.
//    WAIT_GAP: count low cycles, any high restarts count; count==RESET_CYC -> IDLE.
//      Guarantees no decoding from mid-frame after reset or after an error.
//    IDLE: ds rising -> HIGH, hcnt=1. Clear ERR, addr=0 if this is the first bit of a frame.
//    HIGH: hcnt++ each cycle. hcnt>HIGH_MAX_CYC -> ERR=1, WAIT_GAP. On ds falling:
//      hcnt<GLITCH_CYC -> ERR=1, WAIT_GAP; else bit=(hcnt>=T1_MIN_CYC), shift in, -> LOW, lcnt=1.
//    LOW: lcnt++. ds rising -> HIGH (next bit). lcnt==RESET_CYC -> end frame: FRAME_DONE=1
//      for one cycle, FRAME_BYTES=byte count, partial byte discarded and ERR=1 if bitcnt!=0,
//      counters cleared -> IDLE.
//  - Byte complete on 8th bit: WE high exactly one cycle, the cycle after the falling-edge
//    cycle that shifted bit 7; WADDR=current addr; addr increments after the write.
//  - Overflow: bytes beyond MAX_BYTES are not written (WE stays 0), ERR=1; FRAME_BYTES
//    saturates at MAX_BYTES. Address never wraps within a frame.
//  - Counters saturate (hcnt at HIGH_MAX_CYC+1, lcnt at RESET_CYC); no wrap-around.
//  - Rising edge and gap can't coincide (gap needs ds low); FRAME_DONE and a WE never
//    occur in the same cycle (WE precedes gap by >=RESET_CYC).
//  - RST_N low mid-frame: immediate return to reset state; partial data lost; no FRAME_DONE.
//  - Latency DIN edge -> internal sampling: 2 CLK (synchroniser).
// CONFIGURATION
//  NEOPIXEL_RX_PASSTHRU_EN defined: extra port DOUT (out, 1, reset 0) acts like a WS2812
//    cell: DOUT is held low for the first 24 bits of each frame (this cell's pixel) and
//    equals ds (2-cycle delayed DIN) for all subsequent bits and gaps; the 24-bit window
//    ends at the falling edge of bit 23, so bit 24's rising edge is forwarded in full.
//  Not defined: no DOUT port, no forwarding logic; all other behaviour identical.
// TESTING
//  1 Reset, DIN low 600 cyc, send bytes 0xA5,0x3C (T0H=5/T1H=10, period 15) then 600 low
//    -> WE at addr0=0xA5, addr1=0x3C; FRAME_DONE once; FRAME_BYTES=2; ERR=0.
//  2 Bits without preceding gap after reset -> no WE until a 600-cycle gap, then frame decodes.
//  3 High pulses of 7 and 8 cycles -> decode 0 and 1; 1-cycle pulse -> ERR=1, WAIT_GAP; 21 -> ERR.
//  4 Frame of 12 bits then gap -> one byte written, FRAME_BYTES=1, ERR=1; next frame clears ERR.
//  5 513 bytes sent -> 512 writes (addr 0..511), ERR=1, FRAME_BYTES=512; low of 599 between
//    bits does not end frame.
//  6 PASSTHRU_EN: 48-bit frame -> DOUT low for bits 0-23, bits 24-47 reproduced on DOUT 2 cyc late.

Source files
------------

// File: rtl/neopixel_rx.sv
// neopixel_rx: WS2812 serial decoder that writes decoded bytes into a framebuffer-style RAM port.
// Optional NEOPIXEL_RX_PASSTHRU_EN adds DOUT, forwarding the stream after this cell's 24 bits.
`timescale 1ns/1ps
module neopixel_rx #(
  parameter int unsigned T1_MIN_CYC   = 8,
  parameter int unsigned GLITCH_CYC   = 2,
  parameter int unsigned HIGH_MAX_CYC = 20,
  parameter int unsigned RESET_CYC    = 600,
  parameter int unsigned MAX_BYTES    = 512
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN,
  output logic [8:0] WADDR,
  output logic [7:0] WDATA,
  output logic       WE,
  output logic       FRAME_DONE,
  output logic [9:0] FRAME_BYTES,
  output logic       ERR
`ifdef NEOPIXEL_RX_PASSTHRU_EN
  ,
  output logic       DOUT
`endif
);

  localparam int unsigned HW = $clog2(HIGH_MAX_CYC + 2);
  localparam int unsigned LW = $clog2(RESET_CYC + 1);
  localparam logic [HW-1:0] HSAT = HW'(HIGH_MAX_CYC + 1);
  localparam logic [LW-1:0] LSAT = LW'(RESET_CYC);

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_e;

  state_e        state_q;
  logic          din_meta_q, ds_q;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q, shift_d;
  logic [9:0]    bytes_q;
  logic [8:0]    waddr_q;
  logic [7:0]    wdata_q;
  logic          we_q, done_q, err_q;
  logic [9:0]    fbytes_q;
  logic          gap_hit, bit_ok;

  always_comb begin
    hcnt_d  = (hcnt_q == HSAT) ? hcnt_q : hcnt_q + HW'(1);
    lcnt_d  = (lcnt_q == LSAT) ? lcnt_q : lcnt_q + LW'(1);
    shift_d = {shift_q[6:0], (hcnt_q >= HW'(T1_MIN_CYC))};
    gap_hit = !ds_q && (lcnt_d == LSAT);
    bit_ok  = (state_q == HIGH) && !ds_q && (hcnt_q >= HW'(GLITCH_CYC));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= WAIT_GAP;
      din_meta_q <= 1'b0;
      ds_q       <= 1'b0;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      bytes_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fbytes_q   <= '0;
    end else begin
      din_meta_q <= DIN;
      ds_q       <= din_meta_q;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        WAIT_GAP: begin
          if (ds_q) begin
            lcnt_q <= '0;
          end else if (gap_hit) begin
            lcnt_q  <= '0;
            state_q <= IDLE;
          end else begin
            lcnt_q <= lcnt_d;
          end
        end
        IDLE: begin
          if (ds_q) begin
            state_q  <= HIGH;
            hcnt_q   <= HW'(1);
            err_q    <= 1'b0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            bytes_q  <= '0;
          end
        end
        HIGH: begin
          if (ds_q) begin
            if (hcnt_d == HSAT) begin
              err_q   <= 1'b1;
              lcnt_q  <= '0;
              state_q <= WAIT_GAP;
            end else begin
              hcnt_q <= hcnt_d;
            end
          end else if (!bit_ok) begin
            err_q   <= 1'b1;
            lcnt_q  <= '0;
            state_q <= WAIT_GAP;
          end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_q + 3'd1;
            lcnt_q   <= LW'(1);
            state_q  <= LOW;
            // Bytes past the buffer end are dropped; the count saturates there.
            if (bitcnt_q == 3'd7) begin
              if (bytes_q < 10'(MAX_BYTES)) begin
                we_q    <= 1'b1;
                waddr_q <= bytes_q[8:0];
                wdata_q <= shift_d;
                bytes_q <= bytes_q + 10'd1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
        end
        LOW: begin
          if (ds_q) begin
            hcnt_q  <= HW'(1);
            state_q <= HIGH;
          end else if (gap_hit) begin
            done_q   <= 1'b1;
            fbytes_q <= bytes_q;
            if (bitcnt_q != 3'd0) err_q <= 1'b1;
            bitcnt_q <= '0;
            shift_q  <= '0;
            bytes_q  <= '0;
            lcnt_q   <= '0;
            state_q  <= IDLE;
          end else begin
            lcnt_q <= lcnt_d;
          end
        end
        default: state_q <= WAIT_GAP;
      endcase
    end
  end

  assign WADDR       = waddr_q;
  assign WDATA       = wdata_q;
  assign WE          = we_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_BYTES = fbytes_q;
  assign ERR         = err_q;

`ifdef NEOPIXEL_RX_PASSTHRU_EN
  logic [4:0] pcnt_q;
  logic       pass_q;

  // Forwarding opens after bit 23's falling edge and closes on every return to IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcnt_q <= '0;
      pass_q <= 1'b0;
    end else if ((state_q == WAIT_GAP || state_q == LOW) && gap_hit) begin
      pcnt_q <= '0;
      pass_q <= 1'b0;
    end else if (bit_ok && !pass_q) begin
      if (pcnt_q == 5'd23) pass_q <= 1'b1;
      else                 pcnt_q <= pcnt_q + 5'd1;
    end
  end

  assign DOUT = pass_q & ds_q;
`endif

endmodule

// File: tb/tb_neopixel_rx.sv
// tb_neopixel_rx: pulse-level stimulus for neopixel_rx checked against a bit-list frame model.
`timescale 1ns/1ps
module tb_neopixel_rx;
  localparam int RESET_CYC = 600;
  localparam int GAP       = 605;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       DIN = 1'b0;
  logic [8:0] WADDR;
  logic [7:0] WDATA;
  logic       WE, FRAME_DONE, ERR;
  logic [9:0] FRAME_BYTES;
`ifdef NEOPIXEL_RX_PASSTHRU_EN
  logic       DOUT;
`endif

  neopixel_rx dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN),
    .WADDR(WADDR), .WDATA(WDATA), .WE(WE),
    .FRAME_DONE(FRAME_DONE), .FRAME_BYTES(FRAME_BYTES), .ERR(ERR)
`ifdef NEOPIXEL_RX_PASSTHRU_EN
    , .DOUT(DOUT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Observed writes/frame ends, sampled 2 time units after each rising edge.
  logic [16:0] wq[$];
  int          done_cnt = 0;
  bit          dout_chk_en = 1'b0;
  bit          fwd_now = 1'b0;
  bit          exp_dout_q[$];

  always @(posedge CLK) begin
    #2;
    if (WE) wq.push_back({WADDR, WDATA});
    if (FRAME_DONE) begin
      done_cnt++;
      chk("done_we_excl", {31'd0, WE}, 32'd0);
    end
`ifdef NEOPIXEL_RX_PASSTHRU_EN
    if (dout_chk_en && exp_dout_q.size() >= 2)
      chk("dout", {31'd0, DOUT}, {31'd0, exp_dout_q[exp_dout_q.size()-2]});
`endif
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      DIN = v;
      exp_dout_q.push_back(v & fwd_now);
    end
  endtask

  bit tx_bits[$];

  task automatic load_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) tx_bits.push_back(b[k]);
  endtask

  // period>0: low = period-high; rnd: random legal widths; long_at: that bit gets a 599-cycle low.
  task automatic send_bits(input int hi0, input int hi1, input int lo, input int period,
                           input bit rnd, input int long_at);
    for (int i = 0; i < tx_bits.size(); i++) begin
      int h;
      int l;
      if (rnd) begin
        h = tx_bits[i] ? int'($urandom_range(20, 8)) : int'($urandom_range(7, 2));
        l = int'($urandom_range(40, 1));
      end else begin
        h = tx_bits[i] ? hi1 : hi0;
        l = (period > 0) ? period - h : lo;
      end
      if (i == long_at) l = RESET_CYC - 1;
      fwd_now = (i >= 24);
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  logic [7:0] exp_b[$];
  int         exp_fb;
  logic       exp_err;

  // Frame model: complete bytes MSB-first, first 512 kept; partial byte or overflow is an error.
  task automatic model();
    int nbytes;
    logic [7:0] v;
    nbytes = tx_bits.size() / 8;
    exp_b.delete();
    for (int b = 0; b < nbytes && b < 512; b++) begin
      v = 8'h00;
      for (int k = 0; k < 8; k++) v[7-k] = tx_bits[8*b+k];
      exp_b.push_back(v);
    end
    exp_fb  = (nbytes > 512) ? 512 : nbytes;
    exp_err = ((tx_bits.size() % 8) != 0) || (nbytes > 512);
  endtask

  task automatic check_frame(input string tag, input int exp_done);
    chk($sformatf("%s_nwrites", tag), wq.size(), exp_b.size());
    for (int i = 0; i < wq.size() && i < exp_b.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {23'd0, wq[i][16:8]}, i);
      chk($sformatf("%s_data%0d", tag, i), {24'd0, wq[i][7:0]}, {24'd0, exp_b[i]});
    end
    chk($sformatf("%s_done", tag), done_cnt, exp_done);
    if (exp_done != 0) chk($sformatf("%s_fbytes", tag), {22'd0, FRAME_BYTES}, exp_fb);
    chk($sformatf("%s_err", tag), {31'd0, ERR}, {31'd0, exp_err});
    wq.delete();
    done_cnt = 0;
  endtask

  task automatic check_reset(input string tag);
    chk($sformatf("%s_waddr", tag), {23'd0, WADDR}, 32'd0);
    chk($sformatf("%s_wdata", tag), {24'd0, WDATA}, 32'd0);
    chk($sformatf("%s_we", tag), {31'd0, WE}, 32'd0);
    chk($sformatf("%s_done", tag), {31'd0, FRAME_DONE}, 32'd0);
    chk($sformatf("%s_fbytes", tag), {22'd0, FRAME_BYTES}, 32'd0);
    chk($sformatf("%s_err", tag), {31'd0, ERR}, 32'd0);
`ifdef NEOPIXEL_RX_PASSTHRU_EN
    chk($sformatf("%s_dout", tag), {31'd0, DOUT}, 32'd0);
`endif
  endtask

  typedef struct {
    int         hi;
    int         n_we;
    logic [7:0] byte_exp;
    logic       err_exp;
    int         done_exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{1,  0, 8'h00, 1'b1, 0};
    tbl[1] = '{2,  1, 8'h00, 1'b0, 1};
    tbl[2] = '{5,  1, 8'h00, 1'b0, 1};
    tbl[3] = '{7,  1, 8'h00, 1'b0, 1};
    tbl[4] = '{8,  1, 8'hFF, 1'b0, 1};
    tbl[5] = '{10, 1, 8'hFF, 1'b0, 1};
    tbl[6] = '{20, 1, 8'hFF, 1'b0, 1};
    tbl[7] = '{21, 0, 8'h00, 1'b1, 0};

    repeat (3) @(negedge CLK);
    check_reset("rst");
    RST_N = 1'b1;

    // Basic two-byte frame after a full gap.
    drive(1'b0, RESET_CYC);
    tx_bits.delete(); load_byte(8'hA5); load_byte(8'h3C);
    model();
    send_bits(5, 10, 0, 15, 1'b0, -1);
    drive(1'b0, GAP);
    check_frame("t1", 1);

    // Bits straight after reset must be ignored until a gap is seen.
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    tx_bits.delete(); load_byte(8'hFF); load_byte(8'h81);
    send_bits(5, 10, 0, 15, 1'b0, -1);
    drive(1'b0, GAP);
    exp_b.delete(); exp_err = 1'b0;
    check_frame("t2a", 0);
    tx_bits.delete(); load_byte(8'h5A);
    model();
    send_bits(5, 10, 0, 15, 1'b0, -1);
    drive(1'b0, GAP);
    check_frame("t2b", 1);

    // Pulse-width classification and glitch / stuck-high errors.
    for (int v = 0; v < 8; v++) begin
      tx_bits.delete(); load_byte(8'hFF);
      send_bits(tbl[v].hi, tbl[v].hi, 6, 0, 1'b0, -1);
      drive(1'b0, GAP);
      exp_b.delete();
      if (tbl[v].n_we != 0) exp_b.push_back(tbl[v].byte_exp);
      exp_fb  = 1;
      exp_err = tbl[v].err_exp;
      check_frame($sformatf("t3_hi%0d", tbl[v].hi), tbl[v].done_exp);
    end

    // 12-bit frame: one byte, partial byte flags ERR; next frame's first bit clears it.
    tx_bits.delete(); load_byte(8'hC3);
    for (int k = 0; k < 4; k++) tx_bits.push_back(1'b1);
    model();
    send_bits(5, 10, 0, 15, 1'b0, -1);
    drive(1'b0, GAP);
    check_frame("t4a", 1);
    drive(1'b1, 10);
    drive(1'b0, 5);
    chk("t4_err_clear", {31'd0, ERR}, 32'd0);
    tx_bits.delete();
    for (int k = 0; k < 7; k++) tx_bits.push_back(1'b0);
    send_bits(5, 10, 0, 15, 1'b0, -1);
    drive(1'b0, GAP);
    exp_b.delete(); exp_b.push_back(8'h80); exp_fb = 1; exp_err = 1'b0;
    check_frame("t4b", 1);

    // Randomized frames with random legal pulse widths.
    for (int f = 0; f < 6; f++) begin
      int nb;
      nb = 8 * int'($urandom_range(4, 1));
      if ($urandom_range(2, 0) == 0) nb += int'($urandom_range(7, 1));
      tx_bits.delete();
      for (int k = 0; k < nb; k++) tx_bits.push_back(1'($urandom_range(1, 0)));
      model();
      send_bits(0, 0, 0, 0, 1'b1, (f == 2) ? 5 : -1);
      drive(1'b0, GAP);
      check_frame($sformatf("rnd%0d", f), 1);
    end

    // Reset in the middle of a frame: outputs clear at once, no frame end follows.
    tx_bits.delete(); load_byte(8'h96); tx_bits.push_back(1'b1); tx_bits.push_back(1'b0);
    send_bits(5, 10, 0, 15, 1'b0, -1);
    drive(1'b1, 3);
    wq.delete(); done_cnt = 0;
    RST_N = 1'b0;
    DIN = 1'b0;
    @(negedge CLK);
    check_reset("midrst");
    RST_N = 1'b1;
    drive(1'b0, GAP);
    chk("midrst_nodone", done_cnt, 32'd0);
    chk("midrst_nowrite", wq.size(), 32'd0);
    wq.delete(); done_cnt = 0;

    // 513 bytes with a 599-cycle low inside: 512 writes, overflow error.
    tx_bits.delete();
    for (int b = 0; b < 513; b++) load_byte(8'($urandom_range(255, 0)));
    model();
    send_bits(3, 8, 3, 0, 1'b0, 100);
    drive(1'b0, GAP);
    check_frame("t5", 1);

`ifdef NEOPIXEL_RX_PASSTHRU_EN
    // 48-bit frame: first 24 bits absorbed, remainder forwarded two cycles late.
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    fwd_now = 1'b0;
    drive(1'b0, RESET_CYC + 2);
    tx_bits.delete();
    for (int b = 0; b < 6; b++) load_byte(8'($urandom_range(255, 0)));
    model();
    exp_dout_q.delete();
    dout_chk_en = 1'b1;
    send_bits(5, 10, 0, 15, 1'b0, -1);
    drive(1'b0, GAP);
    dout_chk_en = 1'b0;
    fwd_now = 1'b0;
    check_frame("t6", 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
